// File: rtl/perf_defs.sv
// ============================================================
// perf_defs: shared state encoding, halt opcode and result-field indices. Rev 1.0
// ============================================================
`default_nettype none

package perf_defs;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRST  = 3'd1,
        ST_RUN   = 3'd2,
        ST_LATCH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [31:0] HALT_INST_DEF = 32'hA800FFFF;

    localparam int NUM_FIELDS  = 6;
    localparam int F_CYCLES    = 0;
    localparam int F_INSTRS    = 1;
    localparam int F_LU_STALLS = 2;
    localparam int F_BRANCHES  = 3;
    localparam int F_BP_GAIN   = 4;
    localparam int F_BP_LOSS   = 5;

endpackage

`default_nettype wire

// File: rtl/perf_counter_bank.sv
// ============================================================
// perf_counter_bank: six saturating event counters with shared clear. Rev 1.0
// ============================================================
`default_nettype none

module perf_counter_bank
    import perf_defs::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [NUM_FIELDS-1:0] inc,
    output logic [CNT_W-1:0]      count [NUM_FIELDS]
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                count[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                count[i] <= '0;
            end
        end else begin
            // Counters stick at all-ones instead of wrapping.
            for (int i = 0; i < NUM_FIELDS; i++) begin
                if (inc[i] && (count[i] != {CNT_W{1'b1}})) begin
                    count[i] <= count[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/perf_run_controller.sv
// ============================================================
// perf_run_controller: runs forwarding-off/on processor passes and banks their counters. Rev 1.0
// ============================================================
`default_nettype none

module perf_run_controller
    import perf_defs::*;
#(
    parameter int          CNT_W      = 32,
    parameter int          RST_CYCLES = 3,
    parameter int          MAX_CYCLES = 100000,
    parameter logic [31:0] HALT_INST  = HALT_INST_DEF,
    parameter int          NUM_PASSES = 2,
    localparam int         SEL_W      = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      inst_IF,
    input  logic             hazard_detected,
    input  logic             mem_r_en_exe,
    input  logic             is_branch_id,
    input  logic             br_taken_id,
    input  logic             pred_taken_id,
    output logic             proc_rst,
    output logic             forwarding_EN,
    output logic             bp_update_en,
    output logic             busy,
    output logic             done,
    input  logic [SEL_W-1:0] res_sel,
    output logic             res_valid,
    output logic             res_timeout,
    output logic [CNT_W-1:0] res_cycles,
    output logic [CNT_W-1:0] res_instrs,
    output logic [CNT_W-1:0] res_lu_stalls,
    output logic [CNT_W-1:0] res_branches,
    output logic [CNT_W-1:0] res_bp_gain,
    output logic [CNT_W-1:0] res_bp_loss
);

    localparam int BANKS = 1 << SEL_W;
    localparam int PC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;

    state_t                r_state;
    logic [SEL_W-1:0]      r_pass;
    logic [PC_W-1:0]       r_prst_cnt;
    logic                  r_timeout;
    logic [BANKS-1:0]      r_valid;
    logic [BANKS-1:0]      r_bank_to;
    logic [CNT_W-1:0]      r_bank [BANKS][NUM_FIELDS];

    logic [CNT_W-1:0]      w_live [NUM_FIELDS];
    logic [NUM_FIELDS-1:0] w_inc;
    logic [SEL_W-1:0]      w_next_pass;
    logic                  w_halt;
    logic                  w_tmo;
    logic                  w_count;
    logic                  w_issue;
    logic                  w_clear;

    assign w_halt      = (inst_IF == HALT_INST);
    assign w_tmo       = (64'(w_live[F_CYCLES]) == 64'(MAX_CYCLES));
    // Halt and timeout cycles are not counted; abort discards the pass anyway.
    assign w_count     = (r_state == ST_RUN) && !abort && !w_halt && !w_tmo;
    assign w_issue     = !hazard_detected && is_branch_id;
    assign w_clear     = (r_state == ST_IDLE) || (r_state == ST_PRST);
    assign w_next_pass = r_pass + SEL_W'(1);

    assign bp_update_en = w_count && w_issue;

    always_comb begin
        w_inc              = '0;
        w_inc[F_CYCLES]    = w_count;
        w_inc[F_INSTRS]    = w_count && !hazard_detected && (inst_IF != 32'd0);
        w_inc[F_LU_STALLS] = w_count && hazard_detected && mem_r_en_exe;
        w_inc[F_BRANCHES]  = w_count && w_issue;
        w_inc[F_BP_GAIN]   = w_count && w_issue && pred_taken_id && br_taken_id;
        w_inc[F_BP_LOSS]   = w_count && w_issue && pred_taken_id && !br_taken_id;
    end

    perf_counter_bank #(
        .CNT_W (CNT_W)
    ) u_live (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .inc   (w_inc),
        .count (w_live)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_pass        <= '0;
            r_prst_cnt    <= '0;
            r_timeout     <= 1'b0;
            r_valid       <= '0;
            r_bank_to     <= '0;
            proc_rst      <= 1'b1;
            forwarding_EN <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            for (int p = 0; p < BANKS; p++) begin
                for (int f = 0; f < NUM_FIELDS; f++) begin
                    r_bank[p][f] <= '0;
                end
            end
        end else begin
            done <= 1'b0;
            if (abort) begin
                r_state       <= ST_IDLE;
                proc_rst      <= 1'b1;
                forwarding_EN <= 1'b0;
                busy          <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_state       <= ST_PRST;
                            r_pass        <= '0;
                            r_prst_cnt    <= '0;
                            r_timeout     <= 1'b0;
                            r_valid       <= '0;
                            proc_rst      <= 1'b1;
                            forwarding_EN <= 1'b0;
                            busy          <= 1'b1;
                        end
                    end
                    ST_PRST: begin
                        if (r_prst_cnt == PC_W'(RST_CYCLES - 1)) begin
                            r_state  <= ST_RUN;
                            proc_rst <= 1'b0;
                        end else begin
                            r_prst_cnt <= r_prst_cnt + PC_W'(1);
                        end
                    end
                    ST_RUN: begin
                        if (w_halt || w_tmo) begin
                            r_state   <= ST_LATCH;
                            r_timeout <= !w_halt;
                            proc_rst  <= 1'b1;
                        end
                    end
                    ST_LATCH: begin
                        r_bank[r_pass]    <= w_live;
                        r_bank_to[r_pass] <= r_timeout;
                        r_valid[r_pass]   <= 1'b1;
                        if (r_pass == SEL_W'(NUM_PASSES - 1)) begin
                            r_state       <= ST_DONE;
                            done          <= 1'b1;
                            busy          <= 1'b0;
                            forwarding_EN <= 1'b0;
                        end else begin
                            r_state       <= ST_PRST;
                            r_pass        <= w_next_pass;
                            r_prst_cnt    <= '0;
                            r_timeout     <= 1'b0;
                            forwarding_EN <= w_next_pass[0];
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign res_valid     = r_valid[res_sel];
    assign res_timeout   = r_bank_to[res_sel];
    assign res_cycles    = r_bank[res_sel][F_CYCLES];
    assign res_instrs    = r_bank[res_sel][F_INSTRS];
    assign res_lu_stalls = r_bank[res_sel][F_LU_STALLS];
    assign res_branches  = r_bank[res_sel][F_BRANCHES];
    assign res_bp_gain   = r_bank[res_sel][F_BP_GAIN];
    assign res_bp_loss   = r_bank[res_sel][F_BP_LOSS];

endmodule

`default_nettype wire
